lock_query_ctrl: RTL
====================

Name: lock_query_ctrl

Overview:
- Controller for a key-locked combinational core, such as the c432 variant with XOR and mux4 keys.
- Serially loads and commits the key vector that drives the core's key inputs.
- Sequences oracle-style queries: applies a pattern, waits a fixed settle time, captures the outputs and returns them over a valid/ready handshake.
- Sits between the attack/test harness and the locked netlist instance.

Parameters:
N_IN, 36, width of the core primary-input pattern
N_OUT, 7, width of the core primary outputs
N_KEY, 28, key width (24 XOR key bits, then 4 mux key bits; key_out[N_KEY-1:4] = X_24..X_1, key_out[3:0] = p4..p1)
SETTLE, 2, cycles the core inputs are held before capture (must be at least 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
key_sin  in  1  serial key bit
key_sen  in  1  shift enable; key_sin shifts into shadow LSB (MSB first)
key_commit  in  1  copy shadow key into key_out
key_out  out  N_KEY  committed key driven to the core key inputs
key_loaded  out  1  a valid key has been committed since reset
key_err  out  1  one-cycle pulse on a rejected commit
q_valid  in  1  query pattern valid
q_ready  out  1  controller can accept a query
q_pattern  in  N_IN  query input pattern
core_in  out  N_IN  registered pattern to the core primary inputs
core_out  in  N_OUT  core primary outputs
r_valid  out  1  response valid
r_ready  in  1  response accepted
r_data  out  N_OUT  captured core outputs
q_count  out  16  completed responses, wraps at 0xFFFF->0

Behaviour:
- Reset (synchronous, highest priority, any state) clears:
  - key_out, shadow, shift count, key_loaded, key_err;
  - core_in, r_valid, r_data, q_count;
  - state returns to IDLE.
- An in-flight query is dropped on reset.
- FSM states: IDLE, SETTLE, CAPT, RESP.
  - IDLE: accept on q_valid & q_ready. Latch q_pattern into core_in, load the settle counter with SETTLE-1, go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CAPT.
  - CAPT: r_data <= core_out, r_valid <= 1, go to RESP.
  - RESP: hold r_valid and r_data until r_ready. On the handshake edge, clear r_valid, increment q_count, go to IDLE.
- Latency: r_valid rises SETTLE+1 cycles after the accept edge.
  - r_data samples core_out after core_in has been stable for SETTLE full cycles.
- core_in holds its value from an accept until the next accept. It is never cleared by query completion.
- q_ready = (state == IDLE) & key_loaded & ~key_sen & ~key_commit.
  - No query is accepted before the first commit.
  - No query is accepted in a cycle carrying key activity.
- Key shift:
  - Only in IDLE. shadow <= {shadow[N_KEY-2:0], key_sin}.
  - Shift count increments and saturates at N_KEY+1.
  - key_sen outside IDLE is ignored silently.
- Key commit:
  - Accepted only in IDLE with shift count == N_KEY.
  - On accept: key_out <= shadow, key_loaded <= 1, shift count <= 0.
  - Otherwise (wrong count or not IDLE): key_out unchanged, key_err pulses for 1 cycle, shift count <= 0.
- key_commit and key_sen in the same cycle: the commit is evaluated, and the shift is ignored that cycle.
- key_out never changes while state != IDLE, so the key is stable across every query.
- r_valid must not drop before r_ready. r_data is stable while r_valid = 1.

Test Plan:
- Reset, then q_valid = 1 with no key: q_ready stays 0, key_out = 0, no r_valid for 20 cycles.
- Shift 28 bits encoding 0xA5A5A5A, commit: key_out = 0xA5A5A5A, key_loaded = 1, key_err = 0. Shift 27 bits then commit: key_err pulses, key_out still 0xA5A5A5A.
- SETTLE = 2, accept pattern 0x123456789 at edge T: core_in = 0x123456789 after T; r_valid rises at T+3; r_data equals the core model output for that pattern and key.
- Hold r_ready = 0 for 5 cycles: r_valid and r_data stable, q_ready = 0. Then r_ready = 1: q_count increments by 1, q_ready returns the next cycle.
- key_commit asserted during SETTLE: key_err pulses, key_out unchanged, and the response still matches the old key.
- Assert rst in RESP: r_valid = 0, state IDLE, key_loaded = 0, q_count = 0 on the next cycle. After a reload of 1000 random queries, q_count = 1000.

Source files
------------

// File: rtl/lock_query_ctrl.sv
// lock_query_ctrl: serial key loader and settle-and-capture query sequencer for a key-locked core.
// The key is only committed in IDLE, so it stays stable for the whole duration of every query.
module lock_query_ctrl #(
   parameter int N_IN   = 36,
   parameter int N_OUT  = 7,
   parameter int N_KEY  = 28,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_sin,
   input  logic             key_sen,
   input  logic             key_commit,
   output logic [N_KEY-1:0] key_out,
   output logic             key_loaded,
   output logic             key_err,
   input  logic             q_valid,
   output logic             q_ready,
   input  logic [N_IN-1:0]  q_pattern,
   output logic [N_IN-1:0]  core_in,
   input  logic [N_OUT-1:0] core_out,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [N_OUT-1:0] r_data,
   output logic [15:0]      q_count
);
   localparam int CW = $clog2(N_KEY + 2);
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPT, S_RESP} state_t;
   state_t           r_state;
   logic [N_KEY-1:0] r_shadow;
   logic [CW-1:0]    r_cnt;
   logic [SW-1:0]    r_settle;
   logic             w_idle;
   assign w_idle  = r_state == S_IDLE;
   assign q_ready = w_idle & key_loaded & ~key_sen & ~key_commit;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shadow   <= '0;
         r_cnt      <= '0;
         r_settle   <= '0;
         key_out    <= '0;
         key_loaded <= 1'b0;
         key_err    <= 1'b0;
         core_in    <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         q_count    <= '0;
      end else begin
         key_err <= 1'b0;
         // a commit always wins over a same-cycle shift and restarts the bit count
         if (key_commit) begin
            r_cnt <= '0;
            if (w_idle && r_cnt == CW'(N_KEY)) begin
               key_out    <= r_shadow;
               key_loaded <= 1'b1;
            end else begin
               key_err <= 1'b1;
            end
         end else if (key_sen && w_idle) begin
            r_shadow <= {r_shadow[N_KEY-2:0], key_sin};
            if (r_cnt != CW'(N_KEY + 1)) r_cnt <= r_cnt + 1'b1;
         end
         case (r_state)
            S_IDLE:
               if (q_valid && q_ready) begin
                  core_in  <= q_pattern;
                  r_settle <= SW'(SETTLE - 1);
                  r_state  <= S_SETTLE;
               end
            S_SETTLE:
               if (r_settle == '0) r_state <= S_CAPT;
               else r_settle <= r_settle - 1'b1;
            S_CAPT: begin
               r_data  <= core_out;
               r_valid <= 1'b1;
               r_state <= S_RESP;
            end
            S_RESP:
               if (r_ready) begin
                  r_valid <= 1'b0;
                  q_count <= q_count + 1'b1;
                  r_state <= S_IDLE;
               end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
